fifo_rd_stream: RTL and testbench

//  Read-side companion to the 2-deep fifo_dp FIFO: drains a fifo_dp instance through
//  its read_en/data_out/empty port and re-presents the data as a valid/ready stream.

---
 rtl/fifo_rd_pkg.sv | 18 +
 rtl/fifo_rd_skid.sv | 61 ++++++
 rtl/fifo_rd_stream_chk.sv | 17 +
 rtl/fifo_rd_stream.sv | 98 +++++++++
 tb/tb_fifo_rd_stream.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types for the fifo_dp read-side stream adapter.
// The optional statistics counters are enabled by defining FIFO_RD_STATS_EN.
package fifo_rd_pkg;

    localparam int SKID_DEPTH = 2;

    typedef logic [1:0] occ_t;

    // Occupancy step: a push and a pop in the same cycle cancel out.
    function automatic occ_t occ_next(input occ_t occ, input logic push, input logic pop);
        case ({push, pop})
            2'b10:   occ_next = occ + 2'd1;
            2'b01:   occ_next = occ - 2'd1;
            default: occ_next = occ;
        endcase
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer that absorbs fifo_dp read data while the sink stalls.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output occ_t             occ,
    output logic [WIDTH-1:0] pop_data
);

    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    occ_t             occ_q, occ_d;
    logic [WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [WIDTH-1:0] mem_d [SKID_DEPTH];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        occ_d = occ_next(occ_q, push, pop);
    end

    // Buffer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            mem_q    <= mem_d;
        end
    end

    assign occ      = occ_q;
    assign pop_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_rd_stream_chk.sv
// Property checker for fifo_rd_stream: outstanding reads never exceed skid capacity.
module fifo_rd_stream_chk
    import fifo_rd_pkg::*;
(
    input logic clk,
    input logic rst,
    input occ_t occ,
    input logic inflight
);

    a_occ_budget: assert property (@(posedge clk) disable iff (rst)
        (({1'b0, occ} + {2'b00, inflight}) <= 3'd2));

    a_occ_range: assert property (@(posedge clk) disable iff (rst)
        (occ <= 2'd2));

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a fifo_dp through its read port and presents the data as a valid/ready stream.
// Define FIFO_RD_STATS_EN to add the saturating beat_cnt/stall_cnt statistics ports.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [CNT_W-1:0] beat_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    logic       inflight_q, inflight_d;
    logic       pop_s;
    occ_t       occ_s;
    logic [2:0] committed_s;

    // Issue a read only if the beat will have a skid slot once it lands;
    // counting this cycle's pop keeps back-to-back streaming at full rate.
    always_comb begin
        m_valid     = (occ_s != 2'd0);
        pop_s       = m_valid && m_ready;
        committed_s = {1'b0, occ_s} + {2'b00, inflight_q} - {2'b00, pop_s};
        fifo_rd_en  = !fifo_empty && (committed_s < 3'd2);
        inflight_d  = fifo_rd_en;
    end

    // Tracks the read whose data appears on fifo_data next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    fifo_rd_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (fifo_data),
        .pop       (pop_s),
        .occ       (occ_s),
        .pop_data  (m_data)
    );

`ifdef FIFO_RD_STATS_EN
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating counters for delivered beats and stalled cycles.
    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (pop_s && (beat_cnt_q != {CNT_W{1'b1}})) begin
            beat_cnt_d = beat_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
        if (m_valid && !m_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q  <= {CNT_W{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign beat_cnt  = beat_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    logic [CNT_W-1:0] stats_unused_s;
    assign stats_unused_s = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream with a behavioural 2-deep fifo_dp model and scoreboard.
module tb_fifo_rd_stream;
    import fifo_rd_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty = 1'b1;
    logic       fifo_rd_en;
    logic [7:0] fifo_data = 8'h00;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
`ifdef FIFO_RD_STATS_EN
    logic [15:0] beat_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    fifo_rd_stream #(.WIDTH(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef FIFO_RD_STATS_EN
        ,
        .beat_cnt   (beat_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    fifo_rd_stream_chk u_chk (
        .clk      (clk),
        .rst      (rst),
        .occ      (dut.u_skid.occ_q),
        .inflight (dut.inflight_q)
    );

    typedef struct {
        logic       rdy;
        logic       exp_rd_en;
        logic       exp_valid;
        logic       chk_data;
        logic [7:0] exp_data;
    } vec_t;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         beats = 0;
    int         stalls = 0;
    int         first_beat = -1;
    int         last_beat = -1;
    int         first_data = -1;
    logic [7:0] fifo_q[$];
    logic [7:0] sb_q[$];
    logic       smp_rd_en, smp_valid;
    logic [7:0] smp_data;
    vec_t       t2[5];
    vec_t       t4[9];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive m_ready, sample before the edge, then advance the fifo_dp model.
    task automatic cycle(input logic rdy, input logic wr, input logic [7:0] wdata, output logic wr_ok);
        logic rd_s, rst_s;
        logic [7:0] exp_d;
        m_ready = rdy;
        @(negedge clk);
        rd_s      = fifo_rd_en;
        rst_s     = rst;
        smp_rd_en = fifo_rd_en;
        smp_valid = m_valid;
        smp_data  = m_data;
        if (!rst_s) begin
            check("occ_budget", int'(int'(dut.u_skid.occ_q) + int'(dut.inflight_q) <= 2), 1);
            if (m_valid && m_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_beat", int'(m_data), -1);
                end else begin
                    exp_d = sb_q.pop_front();
                    check("beat_order", int'(m_data), int'(exp_d));
                end
                if (first_beat < 0) begin
                    first_beat = cyc;
                    first_data = int'(m_data);
                end
                last_beat = cyc;
                beats++;
            end
            if (m_valid && !m_ready) stalls++;
        end
        @(posedge clk);
        #1;
        cyc++;
        wr_ok = 1'b0;
        if (rst_s) begin
            fifo_q.delete();
            sb_q.delete();
            fifo_data  = 8'h00;
            beats      = 0;
            stalls     = 0;
            first_beat = -1;
            first_data = -1;
        end else begin
            if (rd_s) begin
                if (fifo_q.size() == 0) check("read_of_empty", 1, 0);
                else fifo_data = fifo_q.pop_front();
            end
            if (wr && fifo_q.size() < 2) begin
                fifo_q.push_back(wdata);
                sb_q.push_back(wdata);
                wr_ok = 1'b1;
            end
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic do_reset();
        logic ok;
        rst = 1'b1;
        cycle(1'b0, 1'b0, 8'h00, ok);
        cycle(1'b0, 1'b0, 8'h00, ok);
        rst = 1'b0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] b);
        fifo_q.push_back(a);
        sb_q.push_back(a);
        fifo_q.push_back(b);
        sb_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        logic ok;
        cycle(v.rdy, 1'b0, 8'h00, ok);
        check({tag, "_rd_en"}, int'(smp_rd_en), int'(v.exp_rd_en));
        check({tag, "_valid"}, int'(smp_valid), int'(v.exp_valid));
        if (v.chk_data) check({tag, "_data"}, int'(smp_data), int'(v.exp_data));
    endtask

    initial begin
        logic ok;
        int   n;

        // rdy, exp_rd_en, exp_valid, chk_data, exp_data
        t2[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        t2[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        t2[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h11};
        t2[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h22};
        t2[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

        t4[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        t4[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        t4[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hA5};
        t4[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hA5};
        t4[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hA5};
        t4[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hA5};
        t4[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hA5};
        t4[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h5A};
        t4[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

        // Reset with an empty FIFO: everything idle and zero.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 8'h00, ok);
            check("idle_rd_en", int'(smp_rd_en), 0);
            check("idle_valid", int'(smp_valid), 0);
            check("idle_data", int'(smp_data), 0);
`ifdef FIFO_RD_STATS_EN
            check("idle_beat_cnt", int'(beat_cnt), 0);
            check("idle_stall_cnt", int'(stall_cnt), 0);
`endif
        end

        // Preloaded pair with a ready sink.
        do_reset();
        preload(8'h11, 8'h22);
        for (int i = 0; i < 5; i++) apply_vec(t2[i], "pre");

        // Back-pressure: two reads then hold until the sink becomes ready.
        do_reset();
        preload(8'hA5, 8'h5A);
        for (int i = 0; i < 9; i++) begin
            apply_vec(t4[i], "bp");
            if (i >= 3 && i <= 5) check("bp_occ", int'(dut.u_skid.occ_q), 2);
        end
        check("bp_stall_cycles", stalls, 4);
`ifdef FIFO_RD_STATS_EN
        check("bp_stall_cnt", int'(stall_cnt), 4);
        check("bp_beat_cnt", int'(beat_cnt), 2);
`endif

        // Continuous writes 0x00..0x3F with an always-ready sink.
        do_reset();
        for (int v = 0; v < 64; v++) begin
            n = 0;
            do begin
                cycle(1'b1, 1'b1, 8'(v), ok);
                n++;
            end while (!ok && n < 20);
        end
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'h00, ok);
        check("stream_beats", beats, 64);
        check("stream_rate", last_beat - first_beat, 63);
        check("stream_sb_empty", sb_q.size(), 0);
`ifdef FIFO_RD_STATS_EN
        check("stream_beat_cnt", int'(beat_cnt), 64);
`endif

        // Random sink back-pressure and random writes.
        do_reset();
        n = 0;
        while (beats < 1000 && n < 20000) begin
            cycle(1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom_range(255)), ok);
            n++;
        end
        check("rand_done", int'(beats >= 1000), 1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'h00, ok);
        check("rand_sb_empty", sb_q.size(), 0);
`ifdef FIFO_RD_STATS_EN
        check("rand_beat_cnt", int'(beat_cnt), beats);
        check("rand_stall_cnt", int'(stall_cnt), stalls);
`endif

        // Reset while the skid is full and the FIFO still holds data.
        do_reset();
        preload(8'hB1, 8'hB2);
        cycle(1'b0, 1'b1, 8'hB3, ok);
        cycle(1'b0, 1'b0, 8'h00, ok);
        cycle(1'b0, 1'b0, 8'h00, ok);
        check("mid_occ_full", int'(dut.u_skid.occ_q), 2);
        rst = 1'b1;
        cycle(1'b1, 1'b0, 8'h00, ok);
        rst = 1'b0;
        cycle(1'b1, 1'b1, 8'hC3, ok);
        check("mid_valid_clr", int'(smp_valid), 0);
        check("mid_occ_clr", int'(dut.u_skid.occ_q), 0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'h00, ok);
        check("mid_first_beat", first_data, 32'hC3);
        check("mid_beats", beats, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
